e203_clk_gate_mc: RTL and testbench
===================================

# e203_clk_gate_mc

Multi-channel clock-gating controller for the E203 core and its subsystems, generalising the fixed core/ITCM/DTCM enable logic to NCH independent channels with a programmable idle hysteresis. Each channel's active indication holds its clock enable on for HYST cycles after activity ends. An optional WFI sleep state machine gates every channel, including always-on ones, behind a request/acknowledge handshake. Outputs drive downstream latch-based ICG cells, one per channel.

## Interface
- NCH, 4: number of gated clock channels (1..16).
- HYST, 3: idle cycles a channel stays enabled after its last active cycle (0..2^CNT_W-1).
- CNT_W, 4: hysteresis counter width.
- ALWAYS_ON_MASK, {NCH{1'b0}} with bit0=1: channels never gated by idleness.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- test_mode  in  1  forces every clk_en bit to 1, combinationally.
- core_cgstop  in  1  disables idle gating: all channels on.
- ch_active  in  NCH  per-channel activity, sampled on the clk rising edge.
- core_wfi  in  1  core requests sleep; held until woken.
- clk_en  out  NCH  per-channel clock enable to the ICG.
- wfi_ack  out  1  registered; high only in SLEEP.

## Operation
- Per channel i: counter cnt_i and registered en_q[i]; clk_en[i] = en_q[i] | test_mode.
- When ch_active[i] or core_cgstop is high, cnt_i loads HYST and en_q[i] is set to 1.
- Otherwise, a nonzero cnt_i decrements by 1.
- In that idle case, en_q[i] follows next(cnt_i)!=0. Counters saturate at 0 and never wrap.
- Always-on channel (ALWAYS_ON_MASK[i]=1): en_q[i]=1 in RUN and DRAIN, 0 in SLEEP. Its counter still runs.
- FSM states (macro enabled): RUN, DRAIN, SLEEP.
- RUN -> DRAIN when core_wfi=1.
- DRAIN -> RUN when core_wfi=0.
- DRAIN -> SLEEP when core_wfi=1, core_cgstop=0, ch_active all 0, and every non-always-on en_q is 0.
- SLEEP -> RUN when core_wfi=0, core_cgstop=1, or any ch_active bit is 1.
- In SLEEP, all en_q are 0. A waking ch_active bit loads its counter in the same edge as the exit to RUN.
- wfi_ack = registered (next_state==SLEEP).
- Simultaneous events in DRAIN: core_cgstop high holds the FSM in DRAIN. core_wfi low takes priority and returns to RUN.
- test_mode affects only clk_en. The FSM and counters run normally, and wfi_ack is unaffected.

## Timing
- Reset values: state RUN, cnt_i=HYST, en_q all 1, clk_en all 1, wfi_ack 0.
- Activity to enable: 1 cycle, since en_q is set at the edge that samples ch_active=1.
- Release: if the last edge sampling ch_active=1 is edge k, en_q[i] falls at edge k+HYST.
- HYST=0 makes en_q[i] a 1-cycle-delayed copy of ch_active[i].
- DRAIN to SLEEP: en_q all 0 and wfi_ack=1 after the same edge.
- Wake: en_q of always-on channels and the waking channel is 1 and wfi_ack is 0 after the first edge that samples the wake condition.
- rst asserted in any state: all registers return to reset values at that edge. Sleep is abandoned with no handshake.

## Configuration
- E203_CG_WFI_HANDSHAKE_EN defined: the FSM, the SLEEP gating of always-on channels and wfi_ack are present.
- Not defined: no FSM is built. The ports remain, core_wfi is ignored, wfi_ack is tied 0, always-on en_q is constant 1, and idle gating is unchanged.

## Test plan
Parameters for all scenarios: NCH=4, HYST=3, ALWAYS_ON_MASK=4'b0001, macro defined.
- Reset: hold rst for 2 cycles with random inputs, then release with inputs at 0 -> clk_en=4'b1111 and wfi_ack=0 during and immediately after reset; idle channels 1..3 drop at the 3rd edge after release.
- Pulse ch_active=4'b0100 for 1 cycle at edge k -> clk_en[2] is 1 through edge k+2 and 0 after edge k+3. clk_en[0] stays 1.
- Assert core_wfi with all inputs idle -> DRAIN, then SLEEP; clk_en=4'b0000 and wfi_ack=1 after the same edge. Then raise ch_active[1] -> next edge gives clk_en=4'b0011 and wfi_ack=0.
- Assert core_cgstop=1 with core_wfi=1 -> clk_en=4'b1111 from the next edge and the FSM stays in DRAIN; wfi_ack stays 0 until core_cgstop falls and HYST expires.
- Assert test_mode=1 while in SLEEP -> clk_en=4'b1111 in the same cycle with wfi_ack still 1. Deassert -> clk_en=4'b0000.
- Undefine the macro and assert core_wfi with all inputs idle for 10 cycles -> wfi_ack=0 and clk_en=4'b0001.

Source files
------------

// File: rtl/e203_clk_gate_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : e203_clk_gate_mc_if
// Description : Signal bundle between the clock-gating controller and its
//               environment.
//               master : drives test_mode, core_cgstop, ch_active, core_wfi;
//                        receives clk_en, wfi_ack.
//               slave  : the controller (inverse directions).
//   test_mode   1    force every clk_en bit high (combinational)
//   core_cgstop 1    disable idle gating, all channels on
//   ch_active   NCH  per-channel activity
//   core_wfi    1    core sleep request, held until woken
//   clk_en      NCH  per-channel enable to the ICG cells
//   wfi_ack     1    registered sleep acknowledge
// Revision    : 1.0  initial release
// ============================================================================
interface e203_clk_gate_mc_if #(
  parameter int NCH = 4
);
  logic           test_mode;
  logic           core_cgstop;
  logic [NCH-1:0] ch_active;
  logic           core_wfi;
  logic [NCH-1:0] clk_en;
  logic           wfi_ack;

  modport master (
    output test_mode, core_cgstop, ch_active, core_wfi,
    input  clk_en, wfi_ack
  );

  modport slave (
    input  test_mode, core_cgstop, ch_active, core_wfi,
    output clk_en, wfi_ack
  );
endinterface
`default_nettype wire

// File: rtl/e203_clk_gate_mc.sv
`default_nettype none
// ============================================================================
// Module      : e203_clk_gate_mc
// Description : Multi-channel clock-gating controller. Each channel keeps its
//               clock enable high for HYST cycles after its last active
//               cycle. Channels in ALWAYS_ON_MASK ignore idleness.
//               Optional feature macro: E203_CG_WFI_HANDSHAKE_EN
//                 defined     -> RUN/DRAIN/SLEEP WFI state machine; SLEEP
//                                gates every channel and raises wfi_ack.
//                 not defined -> core_wfi ignored, wfi_ack tied low,
//                                always-on channels constantly enabled.
// Ports       : clk  - sole clock
//               rst  - synchronous active-high reset
//               cg   - e203_clk_gate_mc_if.slave (activity, wfi, enables)
// Revision    : 1.0  initial release
// ============================================================================
module e203_clk_gate_mc #(
  parameter int             NCH            = 4,
  parameter int             HYST           = 3,
  parameter int             CNT_W          = 4,
  parameter logic [NCH-1:0] ALWAYS_ON_MASK = NCH'(1)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  e203_clk_gate_mc_if.slave  cg
);

  localparam logic [CNT_W-1:0] C_HYST = CNT_W'(HYST);

  logic [NCH-1:0] w_en_q;
  logic           w_sleep_nxt;   // next state is SLEEP: force every en_q low

`ifdef E203_CG_WFI_HANDSHAKE_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_wfi_ack;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (cg.core_wfi) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Withdrawn request wins; cgstop or any lingering enable holds DRAIN.
        if (!cg.core_wfi)
          w_state_nxt = ST_RUN;
        else if (!cg.core_cgstop && (cg.ch_active == '0) &&
                 ((w_en_q & ~ALWAYS_ON_MASK) == '0))
          w_state_nxt = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (!cg.core_wfi || cg.core_cgstop || (cg.ch_active != '0))
          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_wfi_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wfi_ack <= (w_state_nxt == ST_SLEEP);
    end
  end

  assign w_sleep_nxt = (w_state_nxt == ST_SLEEP);
  assign cg.wfi_ack  = r_wfi_ack;
`else
  logic w_unused_wfi;
  assign w_unused_wfi = cg.core_wfi;
  assign w_sleep_nxt  = 1'b0;
  assign cg.wfi_ack   = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_act;
    logic             w_en_nxt;
    logic             r_en;

    assign w_act = cg.ch_active[i] | cg.core_cgstop;

    // Reload on activity, otherwise count down and stick at zero.
    assign w_cnt_nxt = w_act            ? C_HYST :
                       (r_cnt != '0)    ? (r_cnt - 1'b1) : r_cnt;

    if (ALWAYS_ON_MASK[i]) begin : g_aon
      assign w_en_nxt = ~w_sleep_nxt;
    end else begin : g_idle
      // Enable on the sampling edge of activity, then while the counter
      // still has cycles left after this edge.
      assign w_en_nxt = ~w_sleep_nxt & (w_act | (w_cnt_nxt != '0));
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= C_HYST;
        r_en  <= 1'b1;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_en  <= w_en_nxt;
      end
    end

    assign w_en_q[i] = r_en;
  end

  assign cg.clk_en = w_en_q | {NCH{cg.test_mode}};

endmodule
`default_nettype wire

// File: tb/tb_e203_clk_gate_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_e203_clk_gate_mc
// Description : Self-checking bench for e203_clk_gate_mc (NCH=4, HYST=3,
//               ALWAYS_ON_MASK=4'b0001). A timestamp-based reference model
//               (edge of last activity per channel) predicts every output;
//               directed scenarios pin the model with literal values, then
//               randomized traffic is compared every cycle.
//               Expectations follow E203_CG_WFI_HANDSHAKE_EN if defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_e203_clk_gate_mc;

  localparam int             NCH  = 4;
  localparam int             HYST = 3;
  localparam logic [NCH-1:0] AOM  = 4'b0001;
`ifdef E203_CG_WFI_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  e203_clk_gate_mc_if #(.NCH(NCH)) cg_if ();

  e203_clk_gate_mc #(
    .NCH(NCH), .HYST(HYST), .CNT_W(4), .ALWAYS_ON_MASK(AOM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cg  (cg_if)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [NCH-1:0] act,
                       input logic [NCH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A channel is enabled after edge e if it was active at e, or fewer than
  // HYST edges have passed since its last active edge.
  int             edge_n = 0;
  int             last_act [NCH];
  int             mst    = 0;      // 0 RUN, 1 DRAIN, 2 SLEEP
  logic [NCH-1:0] m_en   = '1;
  logic           m_ack  = 1'b0;
  bit             m_valid = 1'b0;

  always @(posedge clk) begin
    logic [NCH-1:0] act;
    logic [NCH-1:0] busy_prev;
    edge_n++;
    if (rst) begin
      for (int i = 0; i < NCH; i++) last_act[i] = edge_n;
      mst     = 0;
      m_valid = 1'b1;
    end else begin
      act       = cg_if.ch_active | {NCH{cg_if.core_cgstop}};
      busy_prev = m_en & ~AOM;
      for (int i = 0; i < NCH; i++) if (act[i]) last_act[i] = edge_n;
      if (HS) begin
        case (mst)
          0: if (cg_if.core_wfi) mst = 1;
          1: if (!cg_if.core_wfi) mst = 0;
             else if (!cg_if.core_cgstop && cg_if.ch_active == 0 && busy_prev == 0) mst = 2;
          default: if (!cg_if.core_wfi || cg_if.core_cgstop || cg_if.ch_active != 0) mst = 0;
        endcase
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (mst == 2)    m_en[i] = 1'b0;
      else if (AOM[i]) m_en[i] = 1'b1;
      else             m_en[i] = (edge_n == last_act[i]) || ((edge_n - last_act[i]) < HYST);
    end
    m_ack = (mst == 2);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("clk_en",  cg_if.clk_en, m_en | {NCH{cg_if.test_mode}});
      check("wfi_ack", {3'b000, cg_if.wfi_ack}, {3'b000, m_ack});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string nm, input logic [NCH-1:0] en, input logic ack);
    check({nm, "_en"},  cg_if.clk_en, en);
    check({nm, "_ack"}, {3'b000, cg_if.wfi_ack}, {3'b000, ack});
  endtask

  initial begin
    cg_if.test_mode   = 1'b0;
    cg_if.core_cgstop = 1'b0;
    cg_if.ch_active   = '0;
    cg_if.core_wfi    = 1'b0;

    // Reset with random inputs for two edges.
    for (int c = 0; c < 2; c++) begin
      rst               = 1'b1;
      cg_if.ch_active   = 4'($urandom);
      cg_if.core_cgstop = 1'($urandom);
      cg_if.core_wfi    = 1'($urandom);
      tick(1);
      lit("reset", 4'b1111, 1'b0);
    end
    rst = 1'b0;
    cg_if.ch_active = '0; cg_if.core_cgstop = 1'b0; cg_if.core_wfi = 1'b0;
    tick(1); lit("rel1", 4'b1111, 1'b0);
    tick(1); lit("rel2", 4'b1111, 1'b0);
    tick(1); lit("rel3", 4'b0001, 1'b0);

    // Single-cycle pulse on channel 2.
    cg_if.ch_active = 4'b0100;
    tick(1); lit("pulse_k", 4'b0101, 1'b0);
    cg_if.ch_active = '0;
    tick(1); lit("pulse_k1", 4'b0101, 1'b0);
    tick(1); lit("pulse_k2", 4'b0101, 1'b0);
    tick(1); lit("pulse_k3", 4'b0001, 1'b0);

    // Sleep entry and wake by channel 1.
    cg_if.core_wfi = 1'b1;
    tick(1); lit("drain", 4'b0001, 1'b0);
    tick(1); lit("sleep", HS ? 4'b0000 : 4'b0001, HS);
    cg_if.ch_active = 4'b0010;
    tick(1); lit("wake", 4'b0011, 1'b0);
    cg_if.ch_active = '0;

    // cgstop holds DRAIN with all channels on.
    cg_if.core_cgstop = 1'b1;
    tick(1); lit("cgstop1", 4'b1111, 1'b0);
    tick(1); lit("cgstop2", 4'b1111, 1'b0);
    tick(1); lit("cgstop3", 4'b1111, 1'b0);
    cg_if.core_cgstop = 1'b0;
    tick(1); lit("cgrel1", 4'b1111, 1'b0);
    tick(1); lit("cgrel2", 4'b1111, 1'b0);
    tick(1); lit("cgrel3", 4'b0001, 1'b0);
    tick(1); lit("cgrel4", HS ? 4'b0000 : 4'b0001, HS);

    // test_mode while sleeping acts combinationally on clk_en only.
    cg_if.test_mode = 1'b1;
    #1; lit("tm_on", 4'b1111, HS);
    cg_if.test_mode = 1'b0;
    #1; lit("tm_off", HS ? 4'b0000 : 4'b0001, HS);

    // Long idle WFI.
    tick(10); lit("wfi_idle", HS ? 4'b0000 : 4'b0001, HS);
    cg_if.core_wfi = 1'b0;
    tick(1); lit("wfi_drop", 4'b0001, 1'b0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) cg_if.core_wfi = ~cg_if.core_wfi;
      cg_if.ch_active   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      cg_if.core_cgstop = ($urandom_range(0, 30) == 0);
      cg_if.test_mode   = ($urandom_range(0, 40) == 0);
      rst               = ($urandom_range(0, 400) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
